// File: rtl/bit_serializer_pkg.sv
// bit_serializer_pkg
//   Shared definitions for the parallel-to-serial stage. The state
//   encodings are exported so detector benches can check serializer state
//   by name rather than by raw value.
package bit_serializer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/bit_serializer.sv
// bit_serializer
//   Takes a WIDTH-bit word on a load/ready handshake and emits it one bit
//   per clock on dout, qualified by dout_valid. After the last bit it pulses
//   done for one cycle and then returns to idle. A load that arrives during
//   the done cycle is accepted immediately, so back-to-back words are
//   separated by a single idle cycle.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (has priority over load)
//   load       accept data_in/nbits on an edge where load && ready
//   data_in    word to serialize
//   nbits      number of bits to emit; 0 or >WIDTH means WIDTH
//   ready      high when a load will be accepted (IDLE or DONE)
//   dout       serial data, 0 whenever dout_valid is 0
//   dout_valid dout carries a payload bit this cycle
//   done       single-cycle pulse after the final bit
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for load; outputs quiet
// ST_SHIFT | presenting one payload bit per cycle, cnt bits remaining
// ST_DONE  | done pulse; a load here starts the next word directly
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b0,
  localparam int CW       = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic [CW-1:0]    nbits,
  output logic             ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             done
);

  localparam logic [CW-1:0] WIDTH_CW = CW'(WIDTH);
  localparam logic [CW-1:0] ONE_CW   = CW'(1);

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_load;
  logic             out_bit;

  // Out-of-range requests fall back to a full word.
  assign cnt_load = ((nbits == '0) || (nbits > WIDTH_CW)) ? WIDTH_CW : nbits;

  // The output end of the register is fixed; with MSB_FIRST the top bit
  // goes first even for short words, so only the upper nbits are sent.
  assign out_bit = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (load) begin
            shreg <= data_in;
            cnt   <= cnt_load;
            state <= ST_SHIFT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          shreg <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
          // Checked before decrementing so cnt can never wrap.
          if (cnt != '0) begin
            cnt <= cnt - ONE_CW;
          end
          if (cnt <= ONE_CW) begin
            state <= ST_DONE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready      = (state != ST_SHIFT);
  assign dout_valid = (state == ST_SHIFT);
  assign dout       = (state == ST_SHIFT) & out_bit;
  assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer
//   Directed bench for bit_serializer. One LSB-first and one MSB-first
//   instance share clock and reset. Inputs change and outputs are sampled
//   on the falling edge.
module tb_bit_serializer;

  logic        clk;
  logic        rst;

  logic        load_l, ready_l, dout_l, valid_l, done_l;
  logic [31:0] data_l;
  logic [5:0]  nbits_l;

  logic        load_m, ready_m, dout_m, valid_m, done_m;
  logic [31:0] data_m;
  logic [5:0]  nbits_m;

  int tests;
  int failed;
  int done_seen;

  bit_serializer #(.WIDTH(32), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .load(load_l), .data_in(data_l), .nbits(nbits_l),
    .ready(ready_l), .dout(dout_l), .dout_valid(valid_l), .done(done_l)
  );

  bit_serializer #(.WIDTH(32), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .load(load_m), .data_in(data_m), .nbits(nbits_m),
    .ready(ready_m), .dout(dout_m), .dout_valid(valid_m), .done(done_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done_l) done_seen++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {ready, dout_valid, dout, done}
  function automatic logic [3:0] outs(input bit inst);
    return inst ? {ready_m, valid_m, dout_m, done_m} : {ready_l, valid_l, dout_l, done_l};
  endfunction

  task automatic set_in(input bit inst, input logic ld, input logic [31:0] d, input logic [5:0] n);
    if (inst) begin
      load_m = ld; data_m = d; nbits_m = n;
    end else begin
      load_l = ld; data_l = d; nbits_l = n;
    end
  endtask

  // Loads one word, checks every bit against a software shift of d, then
  // the done cycle and the return to idle. stream holds the emitted bits
  // re-assembled into their original positions.
  task automatic run_word(input bit inst, input logic [31:0] d, input logic [5:0] nb,
                          input int n_eff, input string name, output logic [31:0] stream);
    logic [3:0] o;
    logic       exp_bit;
    stream = '0;
    @(negedge clk);
    set_in(inst, 1'b1, d, nb);
    @(posedge clk);
    for (int i = 0; i < n_eff; i++) begin
      @(negedge clk);
      if (i == 0) set_in(inst, 1'b0, 32'hDEAD_BEEF, 6'd1);
      o = outs(inst);
      exp_bit = inst ? d[31-i] : d[i];
      check($sformatf("%s ctl%0d", name, i), {29'd0, o[3], o[2], o[0]}, 32'h2);
      check($sformatf("%s bit%0d", name, i), {31'd0, o[1]}, {31'd0, exp_bit});
      if (inst) stream[31-i] = o[1];
      else      stream[i]    = o[1];
    end
    @(negedge clk);
    check($sformatf("%s done", name), {28'd0, outs(inst)}, 32'h9);
    @(negedge clk);
    check($sformatf("%s idle", name), {28'd0, outs(inst)}, 32'h8);
  endtask

  initial begin
    logic [31:0] s;
    int          snap;
    tests = 0;
    failed = 0;
    done_seen = 0;
    rst = 1'b1;
    set_in(1'b0, 1'b0, 32'h0, 6'd0);
    set_in(1'b1, 1'b1, 32'hFFFF_FFFF, 6'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset lsb", {28'd0, outs(1'b0)}, 32'h8);
    check("reset msb load held", {28'd0, outs(1'b1)}, 32'h8);
    rst = 1'b0;
    set_in(1'b1, 1'b0, 32'h0, 6'd0);
    @(negedge clk);

    // Full word, LSB first.
    run_word(1'b0, 32'h6AA3_6155, 6'd0, 32, "lsb32", s);
    check("lsb32 stream", s, 32'h6AA3_6155);
    check("lsb32 first byte", {24'd0, s[7:0]}, 32'h55);

    // Full word, MSB first.
    run_word(1'b1, 32'h8000_0001, 6'd0, 32, "msb32", s);
    check("msb32 stream", s, 32'h8000_0001);

    // Short words; bits beyond nbits must never appear.
    run_word(1'b0, 32'h0000_0005, 6'd3, 3, "n3", s);
    check("n3 stream", s, 32'h5);
    run_word(1'b0, 32'hFFFF_FFFD, 6'd3, 3, "n3hi", s);
    check("n3hi stream", s, 32'h5);
    run_word(1'b0, 32'hFFFF_FFFF, 6'd1, 1, "n1", s);
    check("n1 stream", s, 32'h1);
    run_word(1'b1, 32'hA000_0000, 6'd3, 3, "msb n3", s);
    check("msb n3 stream", s, 32'hA000_0000);
    run_word(1'b0, 32'hA5A5_0F0F, 6'd33, 32, "n33", s);
    check("n33 stream", s, 32'hA5A5_0F0F);

    // Load held high: A accepted, ignored through SHIFT, B taken on DONE.
    @(negedge clk);
    set_in(1'b0, 1'b1, 32'h0000_000F, 6'd4);
    @(posedge clk);
    @(negedge clk);
    set_in(1'b0, 1'b1, 32'h0000_0000, 6'd4);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("b2b A%0d", i), {28'd0, outs(1'b0)}, 32'h6);
    end
    @(negedge clk);
    check("b2b gap", {28'd0, outs(1'b0)}, 32'h9);
    @(negedge clk);
    set_in(1'b0, 1'b0, 32'h0, 6'd0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("b2b B%0d", i), {28'd0, outs(1'b0)}, 32'h4);
    end
    @(negedge clk);
    check("b2b B done", {28'd0, outs(1'b0)}, 32'h9);
    @(negedge clk);
    check("b2b idle", {28'd0, outs(1'b0)}, 32'h8);

    // Abort mid-word with reset; the aborted word never reports done.
    snap = done_seen;
    @(negedge clk);
    set_in(1'b0, 1'b1, 32'hFFFF_FFFF, 6'd0);
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) set_in(1'b0, 1'b0, 32'h0, 6'd0);
      check($sformatf("abort bit%0d", i), {28'd0, outs(1'b0)}, 32'h6);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort reset", {28'd0, outs(1'b0)}, 32'h8);
    repeat (40) @(negedge clk);
    check("abort no done", done_seen - snap, 32'd0);
    check("abort idle", {28'd0, outs(1'b0)}, 32'h8);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
